// File: rtl/glyph_fetch_arbiter_pkg.sv
// Shared constants and state encoding for the glyph fetch arbiter.
// The digit glyphs are 8-aligned in char_rom, so base+row never carries.
package glyph_fetch_arbiter_pkg;

  localparam logic [9:0] SPACE_ADDR = 10'o400;
  localparam logic [9:0] DIGIT_BASE = 10'o600;
  localparam int         GLYPH_ROWS = 8;
  localparam int         NUM_DIGITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/glyph_addr_map.sv
// Maps a digit code to the char_rom base address of its glyph.
// Codes outside 0..9 fall back to the space glyph.
module glyph_addr_map
  import glyph_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [7:0]        num,
  output logic [ADDR_W-1:0] base
);

  always_comb begin
    base = ADDR_W'(SPACE_ADDR);
    if (num < 8'(NUM_DIGITS)) begin
      base = ADDR_W'(DIGIT_BASE) + ADDR_W'({num[3:0], 3'b000});
    end
  end

endmodule

// File: rtl/glyph_fetch_arbiter.sv
// Round-robin arbiter sharing one char_rom read port between two digit requesters;
// fetches 8 glyph rows, bit-reverses them and presents the glyph on valid/ready.
//
// Handshakes: a requester is accepted on the rising edge where reqN_valid && reqN_ready;
// the glyph is consumed on the rising edge where glyph_valid && glyph_ready. Valid must
// be held until accepted; glyph_valid and its payload stay stable until consumed.
module glyph_fetch_arbiter
  import glyph_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROWS    = GLYPH_ROWS,
  parameter int ROM_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   req0_valid,
  input  logic [7:0]             req0_num,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [7:0]             req1_num,
  output logic                   req1_ready,
  output logic [ADDR_W-1:0]      rom_address,
  input  logic [DATA_W-1:0]      rom_q,
  output logic                   glyph_valid,
  input  logic                   glyph_ready,
  output logic                   glyph_owner,
  output logic [ROWS*DATA_W-1:0] glyph_rows,
  output logic                   busy,
  output state_t                 dbg_state
);

  localparam int                CNT_W    = $clog2(ROWS);
  localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(ROWS - 1);

  state_t             state;
  logic               last_grant;
  logic               grant;
  logic               grant_any;
  logic [7:0]         num_sel;
  logic [ADDR_W-1:0]  base;
  logic [CNT_W-1:0]   issue_idx;
  logic               issue_v;
  logic [CNT_W-1:0]   cap_idx;
  logic [ROM_LAT-1:0] valid_pipe;
  logic               cap_v;

  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant     = req1_valid;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end
  end

  assign num_sel = grant ? req1_num : req0_num;

  glyph_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
    .num  (num_sel),
    .base (base)
  );

  // Ready is forced low while reset is held, even though state already reads IDLE.
  assign req0_ready = reset_n && (state == IDLE) && grant_any && !grant;
  assign req1_ready = reset_n && (state == IDLE) && grant_any &&  grant;
  assign busy       = (state != IDLE);
  assign dbg_state  = state;

  // issue_v delayed by ROM_LAT marks the cycle a row's data is on rom_q.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe[0] <= issue_v;
      for (int i = 1; i < ROM_LAT; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
      end
    end
  end

  assign cap_v = valid_pipe[ROM_LAT-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      glyph_owner <= 1'b0;
      rom_address <= ADDR_W'(SPACE_ADDR);
      issue_idx   <= '0;
      issue_v     <= 1'b0;
      cap_idx     <= '0;
      glyph_valid <= 1'b0;
      glyph_rows  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            last_grant  <= grant;
            glyph_owner <= grant;
            rom_address <= base;
            issue_idx   <= '0;
            issue_v     <= 1'b1;
            cap_idx     <= '0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (issue_v) begin
            if (issue_idx == LAST_ROW) begin
              issue_v     <= 1'b0;
              rom_address <= ADDR_W'(SPACE_ADDR);
            end else begin
              issue_idx   <= issue_idx + CNT_W'(1);
              rom_address <= rom_address + ADDR_W'(1);
            end
          end
          if (cap_v) begin
            // ROM rows are MSB-first; the display wants bit 0 leftmost.
            for (int r = 0; r < ROWS; r++) begin
              if (cap_idx == CNT_W'(r)) begin
                for (int i = 0; i < DATA_W; i++) begin
                  glyph_rows[r*DATA_W+i] <= rom_q[DATA_W-1-i];
                end
              end
            end
            cap_idx <= cap_idx + CNT_W'(1);
            if (cap_idx == LAST_ROW) begin
              glyph_valid <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (glyph_ready) begin
            glyph_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_fetch_arbiter.sv
// Bench for glyph_fetch_arbiter: table of single/dual requests plus hand-written
// round-robin, backpressure and mid-fetch reset sequences, checked by a scoreboard.
module tb_glyph_fetch_arbiter;
  import glyph_fetch_arbiter_pkg::*;

  localparam int ROM_LAT = 1;
  localparam int GW      = 65;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_num = '0, req1_num = '0;
  logic        req0_ready, req1_ready;
  logic [9:0]  rom_address;
  logic [7:0]  rom_q;
  logic        glyph_valid;
  logic        glyph_ready = 1'b1;
  logic        glyph_owner;
  logic [63:0] glyph_rows;
  logic        busy;
  state_t      dbg_state;

  glyph_fetch_arbiter #(.ROM_LAT(ROM_LAT)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req0_valid  (req0_valid),
    .req0_num    (req0_num),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_num    (req1_num),
    .req1_ready  (req1_ready),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .glyph_valid (glyph_valid),
    .glyph_ready (glyph_ready),
    .glyph_owner (glyph_owner),
    .glyph_rows  (glyph_rows),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- char_rom model ----------------
  function automatic logic [7:0] rom_word(input logic [9:0] a);
    if (a >= 10'o600 && a < 10'o600 + 10'd80) return {4'((a - 10'o600) >> 3), 1'b0, a[2:0]};
    if (a[9:3] == 7'o40) return {4'h5, 1'b0, a[2:0]};
    return 8'hFF;
  endfunction

  logic [7:0] rom_pipe [ROM_LAT];
  always @(posedge clock) begin
    rom_pipe[0] <= rom_word(rom_address);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[ROM_LAT-1];

  // ---------------- reference model ----------------
  function automatic logic [9:0] base_of(input logic [7:0] num);
    if (num < 8'd10) return 10'o600 + 10'({num[3:0], 3'b000});
    return 10'o400;
  endfunction

  function automatic logic [GW-1:0] exp_glyph(input logic owner, input logic [7:0] num);
    logic [63:0] rows;
    logic [7:0]  w;
    for (int k = 0; k < 8; k++) begin
      w = (num < 8'd10) ? {num[3:0], 4'(k)} : {4'h5, 4'(k)};
      for (int i = 0; i < 8; i++) rows[k*8+i] = w[7-i];
    end
    return {owner, rows};
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_err = 0;
  logic [GW-1:0] exp_q[$];
  logic          acc_owner_q[$];
  int            acc_cyc_q[$];
  int            n_acc = 0;
  int            last_acc_cyc = -1000;
  logic [9:0]    last_base = 10'o400;
  logic          prev_gv = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic log_accept(input logic owner, input logic [7:0] num);
    exp_q.push_back(exp_glyph(owner, num));
    acc_owner_q.push_back(owner);
    acc_cyc_q.push_back(cyc);
    last_acc_cyc = cyc;
    last_base    = base_of(num);
    n_acc++;
  endtask

  int          mon_d;
  logic [9:0]  mon_addr;
  logic [GW-1:0] mon_e;

  always @(negedge clock) begin
    #1;
    if (reset_n) begin
      mon_d = cyc - last_acc_cyc;
      mon_addr = (mon_d >= 1 && mon_d <= 8) ? last_base + 10'(mon_d - 1) : 10'o400;
      check("rom_address", rom_address, mon_addr);
      check("ready_onehot", req0_ready & req1_ready, 0);
      if (glyph_valid && !prev_gv) check("latency", mon_d, 8 + ROM_LAT + 1);
      prev_gv = glyph_valid;
      if (glyph_valid && glyph_ready) begin
        if (exp_q.size() == 0) timeout("glyph_unexpected");
        else begin
          mon_e = exp_q.pop_front();
          check("glyph", {glyph_owner, glyph_rows}, mon_e);
        end
      end
      if (req0_valid && req0_ready) log_accept(1'b0, req0_num);
      if (req1_valid && req1_ready) log_accept(1'b1, req1_num);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    #2;
    while (n_acc < target && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (n_acc < target) timeout("wait_accept");
  endtask

  task automatic wait_glyph(input int budget);
    int n = 0;
    #2;
    while (!glyph_valid && n < budget) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (!glyph_valid) timeout("wait_glyph");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v0;
    logic [7:0] n0;
    logic       v1;
    logic [7:0] n1;
    logic       exp_owner;
    logic [7:0] exp_row0;
  } vec_t;

  vec_t tv[6];
  int   nb, acc;

  initial begin
    tv[0] = '{1'b1, 8'd3,   1'b1, 8'd7,   1'b0, 8'h0C};
    tv[1] = '{1'b0, 8'd0,   1'b1, 8'd7,   1'b1, 8'h0E};
    tv[2] = '{1'b1, 8'h0A,  1'b0, 8'd0,   1'b0, 8'h0A};
    tv[3] = '{1'b0, 8'd0,   1'b1, 8'hFF,  1'b1, 8'h0A};
    tv[4] = '{1'b1, 8'd9,   1'b0, 8'd0,   1'b0, 8'h09};
    tv[5] = '{1'b1, 8'd2,   1'b1, 8'd4,   1'b1, 8'h02};

    // Reset state, with a request held to show ready stays low in reset.
    req0_valid = 1'b1;
    req0_num   = 8'd3;
    repeat (3) @(negedge clock);
    #1;
    check("rst_rom_address", rom_address, 10'o400);
    check("rst_glyph_valid", glyph_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rows", glyph_rows, 0);
    check("rst_owner", glyph_owner, 0);
    check("rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven single / dual requests.
    for (int v = 0; v < 6; v++) begin
      @(negedge clock);
      req0_valid = tv[v].v0; req0_num = tv[v].n0;
      req1_valid = tv[v].v1; req1_num = tv[v].n1;
      nb = n_acc;
      wait_acc(nb + 1, 30);
      check("tbl_grant", acc_owner_q[$], tv[v].exp_owner);
      @(negedge clock);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_glyph(30);
      check("tbl_row0", glyph_rows[7:0], tv[v].exp_row0);
      check("tbl_owner", glyph_owner, tv[v].exp_owner);
    end

    // Both requesters held: grants alternate, accepts 11 cycles apart.
    @(negedge clock);
    req0_valid = 1'b1; req0_num = 8'd1;
    req1_valid = 1'b1; req1_num = 8'd2;
    nb = n_acc;
    wait_acc(nb + 4, 100);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) check("rr_owner", acc_owner_q[nb+i], i % 2);
    for (int i = 1; i < 4; i++) check("rr_spacing", acc_cyc_q[nb+i] - acc_cyc_q[nb+i-1], 11);
    wait_glyph(30);

    // Backpressure in DONE with a competing request waiting.
    @(negedge clock);
    glyph_ready = 1'b0;
    req0_valid = 1'b1; req0_num = 8'd5;
    nb = n_acc;
    wait_acc(nb + 1, 30);
    @(negedge clock);
    req0_valid = 1'b0;
    wait_glyph(30);
    req1_valid = 1'b1; req1_num = 8'd8;
    repeat (5) begin
      @(negedge clock);
      #2;
      check("bp_valid", glyph_valid, 1);
      check("bp_glyph", {glyph_owner, glyph_rows}, exp_glyph(1'b0, 8'd5));
      check("bp_req1_ready", req1_ready, 0);
      check("bp_state", dbg_state, DONE);
      check("bp_busy", busy, 1);
    end
    @(negedge clock);
    glyph_ready = 1'b1;
    wait_acc(nb + 2, 30);
    check("bp_next_owner", acc_owner_q[$], 1);
    @(negedge clock);
    req1_valid = 1'b0;
    wait_glyph(30);

    // Reset after row 4 of a fetch, with req1 pending.
    @(negedge clock);
    req0_valid = 1'b1; req0_num = 8'd4;
    nb = n_acc;
    wait_acc(nb + 1, 30);
    acc = acc_cyc_q[$];
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_num = 8'd9;
    while (cyc < acc + 7) @(negedge clock);
    check("pre_rst_state", dbg_state, FETCH);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rom_address", rom_address, 10'o400);
    check("mid_rst_glyph_valid", glyph_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req1_ready", req1_ready, 0);
    check("mid_rst_rows", glyph_rows, 0);
    check("mid_rst_owner", glyph_owner, 0);
    exp_q.delete();
    last_acc_cyc = -1000;
    prev_gv = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_req1_ready", req1_ready, 1);
    check("post_rst_req0_ready", req0_ready, 0);
    wait_acc(nb + 2, 5);
    @(negedge clock);
    req1_valid = 1'b0;
    wait_glyph(30);
    check("post_rst_glyph", {glyph_owner, glyph_rows}, exp_glyph(1'b1, 8'd9));

    repeat (4) @(negedge clock);
    #2;
    check("exp_q_empty", exp_q.size(), 0);
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
